// File: rtl/conv_window_sequencer.sv
`default_nettype none
// conv_window_sequencer: two line buffers plus a 3-column shift register turn a raster pixel stream into 3x3xCH windows.
// Optional build macro CONV_WINSEQ_PERF_EN adds the saturating stall_cnt output.  Rev 1.0
module conv_window_sequencer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int CH     = 3,
    parameter int DW     = 16,
    parameter int STRIDE = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DW-1:0]     in_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9*CH*DW-1:0]   out_window,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done
`ifdef CONV_WINSEQ_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int PXW = CH*DW;
    localparam int WINW = 9*PXW;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W-1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H-1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_LAST = CW'(2 + STRIDE*((IMG_W-3)/STRIDE));
    localparam logic [RW-1:0] ROW_LAST = RW'(2 + STRIDE*((IMG_H-3)/STRIDE));
    localparam logic [PW-1:0] PH_MAX   = PW'(STRIDE-1);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [PW-1:0]   col_ph, row_ph;
    logic [PXW-1:0]  lb0 [IMG_W];
    logic [PXW-1:0]  lb1 [IMG_W];
    logic [PXW-1:0]  win0 [3];
    logic [PXW-1:0]  win1 [3];
    logic [PXW-1:0]  ncol [3];
    logic [WINW-1:0] nwin;
    logic            accept, start_acc, emit, is_last, col_end, frame_end, out_hs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy     = 1'b1;
                in_ready = ~(out_valid & ~out_ready);
                if (in_valid && in_ready && frame_end) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!out_valid || out_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign start_acc = (state == S_IDLE) & start;
    assign col_end   = (col == COL_MAX);
    assign frame_end = col_end & (row == ROW_MAX);
    assign out_hs    = out_valid & out_ready;
    // Phase counters sit at 0 exactly on the stride-aligned positions once r,c >= 2.
    assign emit      = accept & (row >= ROW_TWO) & (col >= COL_TWO) & (row_ph == '0) & (col_ph == '0);
    assign is_last   = (row == ROW_LAST) & (col == COL_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || start_acc) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (accept) begin
            if (col_end) begin
                col    <= '0;
                col_ph <= '0;
                row    <= frame_end ? '0 : row + RW'(1);
                if (row < ROW_TWO || row_ph == PH_MAX) row_ph <= '0;
                else                                   row_ph <= row_ph + PH_ONE;
            end else begin
                col <= col + CW'(1);
                if (col < COL_TWO || col_ph == PH_MAX) col_ph <= '0;
                else                                   col_ph <= col_ph + PH_ONE;
            end
        end
    end

    assign ncol[0] = lb1[col];
    assign ncol[1] = lb0[col];
    assign ncol[2] = in_pixel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < IMG_W; c++) begin
                lb0[c] <= '0;
                lb1[c] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                win0[i] <= '0;
                win1[i] <= '0;
            end
        end else if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_pixel;
            for (int i = 0; i < 3; i++) begin
                win0[i] <= win1[i];
                win1[i] <= ncol[i];
            end
        end
    end

    always_comb begin
        nwin = '0;
        for (int k = 0; k < CH; k++) begin
            for (int i = 0; i < 3; i++) begin
                nwin[k*9*DW + (3*i+0)*DW +: DW] = win0[i][k*DW +: DW];
                nwin[k*9*DW + (3*i+1)*DW +: DW] = win1[i][k*DW +: DW];
                nwin[k*9*DW + (3*i+2)*DW +: DW] = ncol[i][k*DW +: DW];
            end
        end
    end

    // A new window can only load when the output slot is empty or handshaking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            out_last   <= 1'b0;
        end else if (emit) begin
            out_valid  <= 1'b1;
            out_window <= nwin;
            out_last   <= is_last;
        end else if (out_hs) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else if (start_acc) begin
            out_last   <= 1'b0;
        end
    end

`ifdef CONV_WINSEQ_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || start_acc)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
`default_nettype wire

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Streaming front-end controller for the fully-unrolled 3x3 conv layer: accepts a raster-order pixel stream for one frame, keeps two line buffers, and issues one complete 3x3xCH window per output position.
- Window layout and valid timing drive the conv layer's `valid`/`input_act` directly.
- Owns frame sequencing (start, busy, last-window flag, frame-done pulse) and backpressure toward the pixel source.

Parameters:
- IMG_W, 32, input frame width in pixels (>=3)
- IMG_H, 32, input frame height in pixels (>=3)
- CH, 3, input channels per pixel
- DW, 16, bits per channel sample
- STRIDE, 2, window stride in both directions (>=1); no padding ("valid" convolution)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins a frame; ignored unless IDLE
- in_valid  in  1  pixel present
- in_ready  out  1  pixel accepted when in_valid&in_ready
- in_pixel  in  CH*DW  channel k at [k*DW +: DW]
- out_valid  out  1  window present (to conv layer `valid`)
- out_ready  in  1  downstream accepts window
- out_window  out  9*CH*DW  channel k at [k*9*DW +: 9*DW]; within channel, tap t=3*i+j at [t*DW +: DW], i=row (0=top/oldest), j=col (0=left/oldest)
- out_last  out  1  high with the final window of the frame
- busy  out  1  high from start accepted until frame_done
- frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset values:
  - in_ready, out_valid, out_last, busy, frame_done = 0; out_window = 0.
  - Line buffers, window shift registers and counters = 0.
  - FSM = IDLE.
- FSM states:
  - IDLE: in_ready=0. start -> STREAM; clears row/col counters and out_last.
  - STREAM:
    - in_ready = ~(out_valid & ~out_ready).
    - After accepting pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: in_ready=0. When out_valid=0, or the held last window handshakes -> DONE.
  - DONE: frame_done=1 for exactly one cycle, busy=0 -> IDLE.
- Counters:
  - col 0..IMG_W-1 and row 0..IMG_H-1 advance only on input handshake.
  - col wraps to 0 and row increments at col=IMG_W-1.
  - No other event moves them.
- Line buffers:
  - lb0[c] holds row r-1, lb1[c] holds row r-2.
  - On accepting pixel p at (r,c), the new column is {lb1[c], lb0[c], p} (top to bottom); then lb1[c]<=lb0[c] and lb0[c]<=p.
- Window shift register:
  - Holds columns j=0,1; the new column enters as j=2.
  - Shifts every accepted pixel, including across row boundaries. Stale data at c<2 is never emitted.
- Emission condition: accepted pixel has r>=2, c>=2, (r-2)%STRIDE==0, (c-2)%STRIDE==0. Implement the modulo with phase counters, not dividers.
- Emission timing:
  - out_window is registered, and out_valid rises the cycle after the completing pixel's handshake (latency 1).
  - out_last=1 when the emitted window is the last position: r = 2+STRIDE*((IMG_H-3)/STRIDE), c likewise.
- Output hold:
  - out_valid, out_window and out_last hold stable until out_valid&out_ready.
  - out_valid clears on handshake unless a new window is loaded in the same cycle, in which case it stays 1 with the new data.
  - Windows are never dropped or duplicated.
- Simultaneous start in non-IDLE: ignored.
- in_valid in IDLE/DRAIN/DONE: not accepted.
- Reset asserted mid-frame: immediate return to reset state; any partial frame is discarded.
- Windows per frame: ((IMG_W-3)/STRIDE+1) * ((IMG_H-3)/STRIDE+1).

Optional Feature:
- Macro: CONV_WINSEQ_PERF_EN.
- With the macro defined:
  - Extra output port stall_cnt (out, 32): counts cycles with out_valid & ~out_ready.
  - Saturates at 2^32-1, cleared on accepted start and on reset, holds its value in IDLE.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- IMG_W=IMG_H=5, CH=3, STRIDE=1; pixel (r,c) channel k = 256k+16r+c, out_ready=1, in_valid=1 -> 9 windows.
  - First window: out_valid one cycle after pixel (2,2); channel-0 taps 0..8 = 0,1,2,16,17,18,32,33,34; channel-2 tap 0 = 512.
  - out_last only on window 9 (tap 8 = 68).
- Same frame, STRIDE=2 -> exactly 4 windows, centred-bottom-right at pixels (2,2),(2,4),(4,2),(4,4); window 2 channel-0 tap 0 = 2; out_last on window 4.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_window/out_last stable, in_ready=0; after release, no pixel lost and the window sequence matches the first scenario.
- Completion: after the last window handshake -> frame_done pulses exactly once, then busy=0 and in_ready=0. A start pulse during STREAM has no effect on counters.
- Reset mid-frame after 12 pixels -> all outputs 0 in the same cycle. A new start plus full frame then reproduces the first-scenario windows exactly.
- With CONV_WINSEQ_PERF_EN: 3 stall cycles, then 2 more in a later window -> stall_cnt=5; next start clears it to 0.
